// File: rtl/spi_cmd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// spi_cmd_ctrl_pkg
// Shared definitions for the SPI command sequencer: opcode values, the status
// address, FSM state encoding and the decoded command kind. The opcode values
// are also what the SPI shifter and the firmware header generator rely on.
// -----------------------------------------------------------------------------
package spi_cmd_ctrl_pkg;

    localparam logic [7:0] OP_WRITE    = 8'h10;
    localparam logic [7:0] OP_READ     = 8'h11;
    localparam logic [7:0] OP_SET_PER  = 8'h12;
    localparam logic [7:0] OP_SET_ON   = 8'h13;
    localparam logic [7:0] OP_SET_CFG  = 8'h14;
    localparam logic [7:0] OP_COMMIT   = 8'h15;
    localparam logic [7:0] OP_CLRERR   = 8'h16;
    localparam logic [7:0] OP_ERR      = 8'hEE;
    localparam logic [7:0] STATUS_ADDR = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CMD_WRITE  = 3'd0,
        CMD_READ   = 3'd1,
        CMD_STATUS = 3'd2,
        CMD_STAGE  = 3'd3,
        CMD_COMMIT = 3'd4,
        CMD_CLRERR = 3'd5,
        CMD_ERROR  = 3'd6
    } cmd_kind_t;

    // Classify a frame. Address range checks live here so EXEC only has to
    // act on the resulting kind.
    function automatic cmd_kind_t decode_op(input logic [7:0] op,
                                            input logic [7:0] addr,
                                            input int         nregs);
        cmd_kind_t kind;
        kind = CMD_ERROR;
        case (op)
            OP_WRITE:   kind = (int'(addr) < nregs) ? CMD_WRITE : CMD_ERROR;
            OP_READ: begin
                if (addr == STATUS_ADDR)     kind = CMD_STATUS;
                else if (int'(addr) < nregs) kind = CMD_READ;
                else                         kind = CMD_ERROR;
            end
            OP_SET_PER, OP_SET_ON, OP_SET_CFG: kind = CMD_STAGE;
            OP_COMMIT:  kind = CMD_COMMIT;
            OP_CLRERR:  kind = CMD_CLRERR;
            default:    kind = CMD_ERROR;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// -----------------------------------------------------------------------------
// spi_cmd_ctrl_if
// Frame/response handshake between the SPI slave shifter (master modport) and
// the command sequencer (slave modport).
//   frame_valid / frame_data : received command word, 1-cycle strobe
//   busy                     : sequencer is processing a frame
//   resp_valid / resp_data   : response word to load for the next transfer
// -----------------------------------------------------------------------------
interface spi_cmd_ctrl_if;
    logic        frame_valid;
    logic [31:0] frame_data;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_data;

    modport master (
        output frame_valid, frame_data,
        input  busy, resp_valid, resp_data
    );

    modport slave (
        input  frame_valid, frame_data,
        output busy, resp_valid, resp_data
    );
endinterface

// File: rtl/spi_cmd_ctrl_pwm_shadow_regs.sv
// -----------------------------------------------------------------------------
// pwm_shadow_regs
// Double-buffered PWM period/on-time/config. Staging registers are written by
// commands; the active copies only move on a PWM period boundary (pwm_sync)
// when a commit is pending or being requested in the same cycle.
// Ports:
//   clock_in, reset_in (sync, active-low)
//   per_we/on_we/cfg_we, wdata : staging writes
//   commit_req                 : COMMIT executing this cycle
//   pwm_sync                   : period boundary strobe
//   period_o/ontime_o/cfg_o    : active values
//   commit_pending_o           : commit waiting for pwm_sync
// -----------------------------------------------------------------------------
module pwm_shadow_regs #(
    parameter logic [15:0] PER_RST = 16'h00FF
) (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic        per_we,
    input  logic        on_we,
    input  logic        cfg_we,
    input  logic [15:0] wdata,
    input  logic        commit_req,
    input  logic        pwm_sync,
    output logic [15:0] period_o,
    output logic [15:0] ontime_o,
    output logic [15:0] cfg_o,
    output logic        commit_pending_o
);

    logic [15:0] stg_per_q, stg_on_q, stg_cfg_q;
    logic [15:0] stg_per_d, stg_on_d, stg_cfg_d;
    logic [15:0] act_per_q, act_on_q, act_cfg_q;
    logic        pending_q, pending_d;
    logic        apply;

    always_comb begin
        stg_per_d = per_we ? wdata : stg_per_q;
        stg_on_d  = on_we  ? wdata : stg_on_q;
        stg_cfg_d = cfg_we ? wdata : stg_cfg_q;
        // A commit issued on the sync cycle takes effect immediately.
        apply     = pwm_sync && (pending_q || commit_req);
        if (apply)           pending_d = 1'b0;
        else if (commit_req) pending_d = 1'b1;
        else                 pending_d = pending_q;
    end

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            stg_per_q <= PER_RST;
            stg_on_q  <= '0;
            stg_cfg_q <= '0;
            act_per_q <= PER_RST;
            act_on_q  <= '0;
            act_cfg_q <= '0;
            pending_q <= 1'b0;
        end else begin
            stg_per_q <= stg_per_d;
            stg_on_q  <= stg_on_d;
            stg_cfg_q <= stg_cfg_d;
            pending_q <= pending_d;
            // Use the next-state staging so a write landing on the sync
            // edge is the value that goes live.
            if (apply) begin
                act_per_q <= stg_per_d;
                act_on_q  <= stg_on_d;
                act_cfg_q <= stg_cfg_d;
            end
        end
    end

    assign period_o         = act_per_q;
    assign ontime_o         = act_on_q;
    assign cfg_o            = act_cfg_q;
    assign commit_pending_o = pending_q;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// spi_cmd_ctrl
// Executes 32-bit SPI frames {opcode, addr, data} and produces the response
// the shifter sends during the next transfer. Holds the general register file,
// error/overrun status and the PWM shadow registers.
// Ports:
//   clock_in, reset_in (sync, active-low)
//   bus            : frame in / busy / response out handshake
//   pwm_sync       : PWM period boundary strobe
//   regs_flat      : register file, reg i at [16i+15:16i]
//   pwm_period/pwm_ontime/pwm_cfg : active PWM settings
//   commit_pending : commit waiting for pwm_sync
//   err_count      : saturating error counter
// -----------------------------------------------------------------------------
module spi_cmd_ctrl
    import spi_cmd_ctrl_pkg::*;
#(
    parameter int          NREGS       = 16,
    parameter int          DW          = 16,
    parameter logic [15:0] PWM_PER_RST = 16'h00FF
) (
    input  logic                clock_in,
    input  logic                reset_in,
    spi_cmd_ctrl_if.slave       bus,
    input  logic                pwm_sync,
    output logic [NREGS*DW-1:0] regs_flat,
    output logic [15:0]         pwm_period,
    output logic [15:0]         pwm_ontime,
    output logic [15:0]         pwm_cfg,
    output logic                commit_pending,
    output logic [7:0]          err_count
);

    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    state_t      state_q, state_d;
    logic [31:0] frame_q;
    cmd_kind_t   kind_q;
    logic [DW-1:0] regs_q [NREGS];
    logic [7:0]  err_q, err_d;
    logic        overrun_q, overrun_d;
    logic [31:0] resp_q, resp_d;

    logic [7:0]  op, addr;
    logic [15:0] data;
    logic        accept, overrun_evt, exec;
    logic        exec_err, exec_clr, wr_en;
    logic [8:0]  err_sum;

    assign op   = frame_q[31:24];
    assign addr = frame_q[23:16];
    assign data = frame_q[15:0];

    assign accept      = (state_q == ST_IDLE) && bus.frame_valid;
    assign overrun_evt = (state_q != ST_IDLE) && bus.frame_valid;
    assign exec        = (state_q == ST_EXEC);
    assign exec_err    = exec && (kind_q == CMD_ERROR);
    assign exec_clr    = exec && (kind_q == CMD_CLRERR);
    assign wr_en       = exec && (kind_q == CMD_WRITE);

    // ---------------- FSM ----------------
    always_ff @(posedge clock_in) begin
        if (!reset_in) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.frame_valid) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ---------------- frame capture / decode ----------------
    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            frame_q <= '0;
            kind_q  <= CMD_ERROR;
        end else begin
            if (accept) frame_q <= bus.frame_data;
            if (state_q == ST_DECODE) kind_q <= decode_op(op, addr, NREGS);
        end
    end

    // ---------------- register file ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            always_ff @(posedge clock_in) begin
                if (!reset_in)                                 regs_q[gi] <= '0;
                else if (wr_en && (addr == 8'(gi)))            regs_q[gi] <= data;
            end
            assign regs_flat[gi*DW +: DW] = regs_q[gi];
        end
    endgenerate

    // ---------------- error / overrun status ----------------
    // An overrun strobe may coincide with an erroring EXEC, so up to +2.
    always_comb begin
        err_sum = {1'b0, err_q} + {8'd0, exec_err} + {8'd0, overrun_evt};
        if (exec_clr)           err_d = '0;
        else if (err_sum[8])    err_d = 8'hFF;
        else                    err_d = err_sum[7:0];
        if (exec_clr)           overrun_d = 1'b0;
        else if (overrun_evt)   overrun_d = 1'b1;
        else                    overrun_d = overrun_q;
    end

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            err_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            err_q     <= err_d;
            overrun_q <= overrun_d;
        end
    end

    // ---------------- response ----------------
    always_comb begin
        resp_d = resp_q;
        if (exec) begin
            case (kind_q)
                CMD_WRITE:  resp_d = {OP_WRITE, addr, data};
                CMD_READ:   resp_d = {OP_READ, addr, regs_q[addr[AW-1:0]]};
                CMD_STATUS: resp_d = {OP_READ, STATUS_ADDR, err_q, 6'b0,
                                      commit_pending, overrun_q};
                CMD_STAGE:  resp_d = {op, 8'h00, data};
                CMD_COMMIT: resp_d = {OP_COMMIT, 24'h0};
                CMD_CLRERR: resp_d = {OP_CLRERR, 24'h0};
                default:    resp_d = {OP_ERR, op, addr, 8'h00};
            endcase
        end
    end

    always_ff @(posedge clock_in) begin
        if (!reset_in) resp_q <= '0;
        else           resp_q <= resp_d;
    end

    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_data  = resp_q;
    assign err_count      = err_q;

    // ---------------- PWM shadow registers ----------------
    pwm_shadow_regs #(.PER_RST(PWM_PER_RST)) u_pwm (
        .clock_in         (clock_in),
        .reset_in         (reset_in),
        .per_we           (exec && (kind_q == CMD_STAGE) && (op == OP_SET_PER)),
        .on_we            (exec && (kind_q == CMD_STAGE) && (op == OP_SET_ON)),
        .cfg_we           (exec && (kind_q == CMD_STAGE) && (op == OP_SET_CFG)),
        .wdata            (data),
        .commit_req       (exec && (kind_q == CMD_COMMIT)),
        .pwm_sync         (pwm_sync),
        .period_o         (pwm_period),
        .ontime_o         (pwm_ontime),
        .cfg_o            (pwm_cfg),
        .commit_pending_o (commit_pending)
    );

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
module tb_spi_cmd_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pwm_sync;
    logic [255:0] regs_flat;
    logic [15:0]  pwm_period, pwm_ontime, pwm_cfg;
    logic         commit_pending;
    logic [7:0]   err_count;

    int n_assert = 0;
    int n_fail   = 0;

    spi_cmd_ctrl_if bus ();

    spi_cmd_ctrl #(.NREGS(16), .DW(16), .PWM_PER_RST(16'h00FF)) dut (
        .clock_in       (clk),
        .reset_in       (rst_n),
        .bus            (bus.slave),
        .pwm_sync       (pwm_sync),
        .regs_flat      (regs_flat),
        .pwm_period     (pwm_period),
        .pwm_ontime     (pwm_ontime),
        .pwm_cfg        (pwm_cfg),
        .commit_pending (commit_pending),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Strobe one frame; returns at the falling edge after the accept edge.
    task automatic send_frame(input logic [31:0] d);
        @(negedge clk);
        bus.frame_valid = 1'b1;
        bus.frame_data  = d;
        @(negedge clk);
        bus.frame_valid = 1'b0;
    endtask

    // Wait (bounded) for resp_valid; returns cycles waited from the DECODE edge.
    task automatic wait_resp(output int cyc);
        cyc = 0;
        while (bus.resp_valid !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_frame(input string tag, input logic [31:0] d, input logic [31:0] exp);
        int cyc;
        send_frame(d);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_resp(cyc);
        chk({tag, "_lat"}, 32'(cyc), 32'd2);
        chk({tag, "_resp"}, bus.resp_data, exp);
        @(negedge clk);
        chk({tag, "_idle"}, {30'd0, bus.busy, bus.resp_valid}, 32'd0);
        $display("frame %08h -> resp %08h (expected %08h)", d, bus.resp_data, exp);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"},  32'(bus.busy), 32'd0);
        chk({tag, "_rv"},    32'(bus.resp_valid), 32'd0);
        chk({tag, "_resp"},  bus.resp_data, 32'd0);
        chk({tag, "_regs"},  32'(|regs_flat), 32'd0);
        chk({tag, "_per"},   32'(pwm_period), 32'h00FF);
        chk({tag, "_on"},    32'(pwm_ontime), 32'd0);
        chk({tag, "_cfg"},   32'(pwm_cfg), 32'd0);
        chk({tag, "_pend"},  32'(commit_pending), 32'd0);
        chk({tag, "_err"},   32'(err_count), 32'd0);
    endtask

    initial begin
        int cyc;
        int nresp;
        bus.frame_valid = 1'b0;
        bus.frame_data  = '0;
        pwm_sync        = 1'b0;
        rst_n           = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("rst");
        rst_n = 1'b1;

        // 1: write then read back
        do_frame("t1_wr", 32'h1001AAAA, 32'h1001AAAA);
        do_frame("t1_rd", 32'h11010000, 32'h1101AAAA);

        // 2: overwrite and read back, check flattened register file
        do_frame("t2_wr", 32'h10015555, 32'h10015555);
        do_frame("t2_rd", 32'h11010000, 32'h11015555);
        chk("t2_reg1", {16'd0, regs_flat[31:16]}, 32'h5555);
        chk("t2_reg0", {16'd0, regs_flat[15:0]}, 32'h0);

        // 3: staged PWM commit waits for pwm_sync
        do_frame("t3_per", 32'h120003E8, 32'h120003E8);
        do_frame("t3_on",  32'h130001F4, 32'h130001F4);
        do_frame("t3_cmt", 32'h15000000, 32'h15000000);
        chk("t3_pend1", 32'(commit_pending), 32'd1);
        repeat (3) @(negedge clk);
        chk("t3_per_hold", 32'(pwm_period), 32'h00FF);
        chk("t3_on_hold",  32'(pwm_ontime), 32'h0);
        pwm_sync = 1'b1;
        @(negedge clk);
        pwm_sync = 1'b0;
        chk("t3_per_act", 32'(pwm_period), 32'h03E8);
        chk("t3_on_act",  32'(pwm_ontime), 32'h01F4);
        chk("t3_cfg_act", 32'(pwm_cfg), 32'h0);
        chk("t3_pend0",   32'(commit_pending), 32'd0);
        $display("commit applied: period %04h ontime %04h", pwm_period, pwm_ontime);

        // sync without pending commit: active values unchanged
        do_frame("t3_per2", 32'h12001234, 32'h12001234);
        pwm_sync = 1'b1;
        @(negedge clk);
        pwm_sync = 1'b0;
        chk("t3_nopend", 32'(pwm_period), 32'h03E8);
        $display("sync without pending: period %04h", pwm_period);

        // COMMIT executing on the sync cycle applies at once
        send_frame(32'h15000000);
        @(negedge clk);              // now in EXEC
        pwm_sync = 1'b1;
        @(negedge clk);              // now in RESP
        pwm_sync = 1'b0;
        chk("t3_same_rv",   32'(bus.resp_valid), 32'd1);
        chk("t3_same_resp", bus.resp_data, 32'h15000000);
        chk("t3_same_per",  32'(pwm_period), 32'h1234);
        chk("t3_same_pend", 32'(commit_pending), 32'd0);
        @(negedge clk);
        $display("commit+sync same cycle: period %04h pending %0d", pwm_period, commit_pending);

        // 4: errors
        do_frame("t4_wrbad", 32'h10200001, 32'hEE102000);
        chk("t4_err1", 32'(err_count), 32'd1);
        do_frame("t4_badop", 32'h99000000, 32'hEE990000);
        chk("t4_err2", 32'(err_count), 32'd2);
        do_frame("t4_rdbad", 32'h11200000, 32'hEE112000);
        chk("t4_err3", 32'(err_count), 32'd3);
        do_frame("t4_stat", 32'h11FF0000, 32'h11FF0300);

        // 5: back-to-back frames, second one dropped
        @(negedge clk);
        bus.frame_valid = 1'b1;
        bus.frame_data  = 32'h10020077;
        @(negedge clk);
        bus.frame_data  = 32'h10030099;
        @(negedge clk);
        bus.frame_valid = 1'b0;
        nresp = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.resp_valid === 1'b1) nresp++;
            @(negedge clk);
        end
        chk("t5_nresp", 32'(nresp), 32'd1);
        chk("t5_resp",  bus.resp_data, 32'h10020077);
        chk("t5_reg2",  {16'd0, regs_flat[47:32]}, 32'h0077);
        chk("t5_reg3",  {16'd0, regs_flat[63:48]}, 32'h0);
        chk("t5_err",   32'(err_count), 32'd4);
        $display("overrun: %0d responses, err_count %0d", nresp, err_count);
        do_frame("t5_stat",  32'h11FF0000, 32'h11FF0401);
        do_frame("t5_clr",   32'h16000000, 32'h16000000);
        do_frame("t5_stat2", 32'h11FF0000, 32'h11FF0000);

        // 6: reset during EXEC of a WRITE aborts it
        send_frame(32'h10040BEE);
        @(negedge clk);              // now in EXEC
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nresp = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.resp_valid === 1'b1) nresp++;
            @(negedge clk);
        end
        chk("t6_nresp", 32'(nresp), 32'd0);
        chk_reset_state("t6");
        $display("reset mid-exec: responses %0d, regs %0h", nresp, regs_flat[79:64]);

        // post-reset sanity: a normal frame still works
        do_frame("t6_after", 32'h1000BEEF, 32'h1000BEEF);
        wait_resp(cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
